// File: rtl/bcd_serial_adder_pkg.sv
// Shared definitions for the digit-serial BCD adder: FSM state encoding,
// BCD constants and a digit range helper.
package bcd_serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;

  // A nibble above 9 is not a legal BCD digit.
  function automatic logic digit_bad(input logic [3:0] d);
    return (d > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_serial_adder_digit_add.sv
// Combinational one-digit BCD adder with decimal adjust; also flags
// operand digits that are out of BCD range.
module bcd_digit_add
  import bcd_serial_adder_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       bad
);

  logic [4:0] raw_s;
  logic [4:0] adj_s;

  // Binary add, then +6 adjust whenever the raw sum leaves the decimal range.
  always_comb begin
    raw_s = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
    adj_s = raw_s + {1'b0, BCD_ADJ};
    bad   = digit_bad(x) | digit_bad(y);
    if (raw_s > {1'b0, BCD_MAX}) begin
      s  = adj_s[3:0];
      co = 1'b1;
    end else begin
      s  = raw_s[3:0];
      co = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder: latches two operands on start, adds one
// digit pair per clock LSD first, and reports the sum with a done pulse.
module bcd_serial_adder
  import bcd_serial_adder_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic                cout,
  output logic                invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  state_t          state_r;
  state_t          state_nx_s;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic [W-1:0]    result_r;
  logic [CW-1:0]   count_r;
  logic            carry_r;
  logic            cout_r;
  logic            invalid_r;
  logic            busy_r;
  logic            done_r;

  logic            accept_s;
  logic            last_s;
  logic [3:0]      sum_s;
  logic            co_s;
  logic            bad_s;
  logic [W+3:0]    shifted_s;

  bcd_digit_add u_digit (
    .x   (a_r[3:0]),
    .y   (b_r[3:0]),
    .ci  (carry_r),
    .s   (sum_s),
    .co  (co_s),
    .bad (bad_s)
  );

  // Control decodes; the sum digit enters the result from the MSD end.
  always_comb begin
    accept_s  = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
    last_s    = (count_r == LAST);
    shifted_s = {sum_s, result_r};
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nx_s = ST_RUN;
        else       state_nx_s = ST_IDLE;
      end
      ST_RUN: begin
        if (last_s) state_nx_s = ST_DONE;
        else        state_nx_s = ST_RUN;
      end
      ST_DONE: begin
        if (start) state_nx_s = ST_RUN;
        else       state_nx_s = ST_IDLE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nx_s;
  end

  // Operand/result shift registers, carry chain, counter and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r       <= '0;
      b_r       <= '0;
      result_r  <= '0;
      count_r   <= '0;
      carry_r   <= 1'b0;
      cout_r    <= 1'b0;
      invalid_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      busy_r <= (state_nx_s == ST_RUN);
      done_r <= (state_nx_s == ST_DONE);
      if (accept_s) begin
        a_r       <= a;
        b_r       <= b;
        carry_r   <= cin;
        invalid_r <= 1'b0;
        count_r   <= '0;
      end else if (state_r == ST_RUN) begin
        a_r       <= a_r >> 4;
        b_r       <= b_r >> 4;
        result_r  <= shifted_s[W+3:4];
        carry_r   <= co_s;
        invalid_r <= invalid_r | bad_s;
        count_r   <= count_r + CW'(1);
        if (last_s) cout_r <= co_s;
      end
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign result  = result_r;
  assign cout    = cout_r;
  assign invalid = invalid_r;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder: directed corner cases plus random
// operands checked against a decimal-arithmetic reference model.
module tb_bcd_serial_adder;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [W-1:0] a, b, result;
  logic         busy, done, cout, invalid;
  logic         start1, cin1;
  logic [3:0]   a1, b1, result1;
  logic         busy1, done1, cout1, invalid1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bcd_serial_adder #(.DIGITS(D)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout), .invalid(invalid)
  );

  bcd_serial_adder #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .result(result1), .cout(cout1), .invalid(invalid1)
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic         co;
    logic         inv;
  } ref_t;

  // Legal operands: add as decimal numbers. Otherwise apply the digit rule.
  function automatic ref_t ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    ref_t        r;
    int unsigned dx, dy, pw, s, cc, raw, ex, ey;
    r  = '0;
    dx = 0; dy = 0; pw = 1;
    for (int i = D - 1; i >= 0; i--) begin
      ex = x[4*i +: 4];
      ey = y[4*i +: 4];
      if (ex > 9 || ey > 9) r.inv = 1'b1;
      dx = dx * 10 + ex;
      dy = dy * 10 + ey;
      pw = pw * 10;
    end
    if (!r.inv) begin
      s    = dx + dy + c;
      r.co = (s >= pw);
      s    = s % pw;
      for (int i = 0; i < D; i++) begin
        r.sum[4*i +: 4] = 4'(s % 10);
        s = s / 10;
      end
    end else begin
      cc = c;
      for (int i = 0; i < D; i++) begin
        raw = x[4*i +: 4] + y[4*i +: 4] + cc;
        if (raw > 9) begin
          r.sum[4*i +: 4] = 4'((raw + 6) % 16);
          cc = 1;
        end else begin
          r.sum[4*i +: 4] = 4'(raw);
          cc = 0;
        end
      end
      r.co = cc[0];
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the first RUN cycle's negedge.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    a = x; b = y; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", busy, 1);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_done(input string tag, input ref_t r, input int cyc);
    check({tag, "_latency"}, cyc, D + 1);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_result"}, result, r.sum);
    check({tag, "_cout"}, cout, r.co);
    check({tag, "_invalid"}, invalid, r.inv);
  endtask

  task automatic run_check(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int cyc;
    launch(x, y, c);
    wait_done(cyc);
    check_done(tag, ref_add(x, y, c), cyc);
    @(negedge clk);
    check({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    int   cyc;
    ref_t r;
    bit   seen;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = 4'd0; b1 = 4'd0; cin1 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_cout", cout, 0);
    check("rst_invalid", invalid, 0);
    check("rst1_result", result1, 0);
    rst = 1'b0;
    @(negedge clk);

    run_check("d1234", 16'h1234, 16'h5678, 1'b0);
    run_check("d9999p1", 16'h9999, 16'h0001, 1'b0);
    run_check("d9999x2", 16'h9999, 16'h9999, 1'b1);
    run_check("dzero", 16'h0000, 16'h0000, 1'b0);
    run_check("dbad", 16'h12A4, 16'h0000, 1'b0);
    run_check("dclean", 16'h1111, 16'h2222, 1'b0);

    // Outputs hold through IDLE while operand inputs wander.
    a = 16'h8888; b = 16'h7777; cin = 1'b1;
    repeat (3) @(negedge clk);
    check("hold_result", result, 16'h3333);
    check("hold_cout", cout, 0);
    check("hold_busy", busy, 0);

    // start held through RUN must not restart; operand changes are ignored.
    a = 16'h4321; b = 16'h1111; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    a = 16'h9999; b = 16'h9999; cin = 1'b0;
    wait_done(cyc);
    start = 1'b0;
    check_done("held", ref_add(16'h4321, 16'h1111, 1'b1), cyc);
    @(negedge clk);
    check("held_idle_busy", busy, 0);
    check("held_idle_done", done, 0);

    // Back-to-back: second start issued during the DONE cycle.
    launch(16'h0456, 16'h0544, 1'b0);
    wait_done(cyc);
    check_done("b2b_first", ref_add(16'h0456, 16'h0544, 1'b0), cyc);
    launch(16'h0999, 16'h0001, 1'b1);
    wait_done(cyc);
    check_done("b2b_second", ref_add(16'h0999, 16'h0001, 1'b1), cyc);
    @(negedge clk);

    for (int n = 0; n < 20; n++) begin
      logic [W-1:0] x, y;
      int           pos;
      for (int i = 0; i < D; i++) begin
        x[4*i +: 4] = 4'($urandom_range(0, 9));
        y[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 4) == 0) begin
        pos = $urandom_range(0, D - 1);
        x[4*pos +: 4] = 4'($urandom_range(10, 15));
      end
      run_check("rand", x, y, 1'($urandom_range(0, 1)));
    end

    // Reset in the second RUN cycle aborts without a done pulse.
    launch(16'h5555, 16'h4444, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_cout", cout, 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check("abort_no_done", seen, 0);

    // Single-digit instance: one RUN cycle.
    a1 = 4'd7; b1 = 4'd5; cin1 = 1'b0; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("one_busy", busy1, 1);
    cyc = 1;
    while (done1 !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("one_latency", cyc, 2);
    check("one_result", result1, 4'd2);
    check("one_cout", cout1, 1);
    check("one_invalid", invalid1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
